// File: rtl/bcd_countdown.sv
// +----------------------------------------------------------------------------+
// | bcd_countdown : N-digit packed-BCD countdown timer, load/start/pause/done  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module bcd_countdown #(
  parameter int DIGITS = 3,
  parameter int WRAP   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   count_out,
  output logic                  running,
  output logic                  zero,
  output logic                  done,
  output logic                  invalid
);

  localparam bit c_WRAP = (WRAP != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  logic [4*DIGITS-1:0]   r_count;
  logic [4*DIGITS-1:0]   r_reload;
  logic                  r_done;
  logic                  r_invalid;

  logic [4*DIGITS-1:0]   w_load_clean;
  logic [DIGITS-1:0]     w_nib_bad;
  logic [4*DIGITS-1:0]   w_dec;
  logic [DIGITS-1:0]     w_borrow;
  logic                  w_count_zero;
  logic                  w_dec_zero;

  assign w_borrow[0] = 1'b1;

  // Per-digit clamp of the load value and ripple-borrow BCD decrement.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [3:0] w_dig_in;
    logic [3:0] w_dig_cur;

    assign w_dig_in  = load_value[4*g +: 4];
    assign w_dig_cur = r_count[4*g +: 4];

    assign w_nib_bad[g]            = (w_dig_in > 4'd9);
    assign w_load_clean[4*g +: 4]  = w_nib_bad[g] ? 4'd9 : w_dig_in;

    assign w_dec[4*g +: 4] = !w_borrow[g]        ? w_dig_cur :
                             (w_dig_cur == 4'd0) ? 4'd9      :
                                                   w_dig_cur - 4'd1;

    if (g < DIGITS - 1) begin : g_chain
      assign w_borrow[g+1] = w_borrow[g] && (w_dig_cur == 4'd0);
    end
  end

  assign w_count_zero = (r_count == '0);
  assign w_dec_zero   = (w_dec == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_done    <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_count  <= w_load_clean;
        r_reload <= w_load_clean;
        r_state  <= S_IDLE;
        if (|w_nib_bad) begin
          r_invalid <= 1'b1;
        end
      end else if (start && (r_state == S_IDLE || r_state == S_PAUSED)) begin
        r_state <= S_RUN;
      end else if (start && (r_state == S_DONE) && c_WRAP) begin
        r_count <= r_reload;
        r_state <= S_RUN;
      end else if (r_state == S_RUN) begin
        if (pause) begin
          r_state <= S_PAUSED;
        end else if (w_count_zero) begin
          // Zero while running: non-wrapping counter finishes without a tick.
          if (!c_WRAP) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (tick) begin
            r_count <= r_reload;
            r_done  <= (r_reload == '0);
          end
        end else if (tick) begin
          r_count <= w_dec;
          if (w_dec_zero) begin
            r_done <= 1'b1;
            if (!c_WRAP) begin
              r_state <= S_DONE;
            end
          end
        end
      end
    end
  end

  assign count_out = r_count;
  assign running   = (r_state == S_RUN);
  assign zero      = w_count_zero;
  assign done      = r_done;
  assign invalid   = r_invalid;

endmodule

`default_nettype wire

// File: tb/tb_bcd_countdown.sv
// +----------------------------------------------------------------------------+
// | tb_bcd_countdown : decimal-value model vs. WRAP=0 and WRAP=1 counters      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bcd_countdown;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_DONE   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [11:0] load_value = 12'h000;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        tick = 1'b0;

  logic [11:0] co0, co1;
  logic        run0, run1, zr0, zr1, dn0, dn1, inv0, inv1;

  int total = 0;
  int bad   = 0;

  // Model state per instance: index 0 is WRAP=0, index 1 is WRAP=1.
  int m_val[2]  = '{0, 0};
  int m_rel[2]  = '{0, 0};
  int m_st[2]   = '{M_IDLE, M_IDLE};
  bit m_done[2] = '{1'b0, 1'b0};
  bit m_inv[2]  = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  bcd_countdown #(.DIGITS(3), .WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .tick(tick),
    .count_out(co0), .running(run0), .zero(zr0), .done(dn0), .invalid(inv0)
  );

  bcd_countdown #(.DIGITS(3), .WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .tick(tick),
    .count_out(co1), .running(run1), .zero(zr1), .done(dn1), .invalid(inv1)
  );

  function automatic int san_val(input logic [11:0] v);
    int r;
    int d;
    r = 0;
    for (int i = 2; i >= 0; i--) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [11:0] v);
    return (v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v[11:8] > 4'd9);
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < 2; w++) begin
        m_val[w] = 0; m_rel[w] = 0; m_st[w] = M_IDLE; m_done[w] = 1'b0; m_inv[w] = 1'b0;
      end
    end else begin
      for (int w = 0; w < 2; w++) begin
        bit wr;
        wr = (w == 1);
        m_done[w] = 1'b0;
        if (load) begin
          m_val[w] = san_val(load_value);
          m_rel[w] = m_val[w];
          m_st[w]  = M_IDLE;
          if (has_bad(load_value)) m_inv[w] = 1'b1;
        end else if (start && (m_st[w] == M_IDLE || m_st[w] == M_PAUSED)) begin
          m_st[w] = M_RUN;
        end else if (start && m_st[w] == M_DONE && wr) begin
          m_val[w] = m_rel[w];
          m_st[w]  = M_RUN;
        end else if (m_st[w] == M_RUN) begin
          if (pause) begin
            m_st[w] = M_PAUSED;
          end else if (m_val[w] == 0) begin
            if (!wr) begin
              m_st[w] = M_DONE; m_done[w] = 1'b1;
            end else if (tick) begin
              m_val[w] = m_rel[w]; m_done[w] = (m_rel[w] == 0);
            end
          end else if (tick) begin
            m_val[w] = m_val[w] - 1;
            if (m_val[w] == 0) begin
              m_done[w] = 1'b1;
              if (!wr) m_st[w] = M_DONE;
            end
          end
        end
      end
    end
  end

  task automatic cmp_inst(input int w, input logic [11:0] c, input logic r, z, d, i);
    chk($sformatf("count_w%0d", w),   c, to_bcd(m_val[w]));
    chk($sformatf("running_w%0d", w), {11'b0, r}, {11'b0, m_st[w] == M_RUN});
    chk($sformatf("zero_w%0d", w),    {11'b0, z}, {11'b0, m_val[w] == 0});
    chk($sformatf("done_w%0d", w),    {11'b0, d}, {11'b0, m_done[w]});
    chk($sformatf("invalid_w%0d", w), {11'b0, i}, {11'b0, m_inv[w]});
  endtask

  always @(negedge clk) begin
    cmp_inst(0, co0, run0, zr0, dn0, inv0);
    cmp_inst(1, co1, run1, zr1, dn1, inv1);
  end

  task automatic drive(input bit l, input logic [11:0] lv, input bit s, input bit p, input bit t);
    load = l; load_value = lv; start = s; pause = p; tick = t;
    @(posedge clk);
    #2;
    load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
  endtask

  initial begin
    logic [11:0] lv;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("rst_count", co0, 12'h000);
    chk("rst_zero", {11'b0, zr0}, 12'h001);
    chk("rst_running", {11'b0, run0}, 12'h000);
    chk("rst_invalid", {11'b0, inv0}, 12'h000);

    drive(1, 12'h260, 0, 0, 0); drive(0, 12'h000, 1, 0, 0); drive(0, 12'h000, 0, 0, 1);
    chk("dec_260", co0, 12'h259);

    drive(1, 12'h100, 0, 0, 0); drive(0, 12'h000, 1, 0, 0); drive(0, 12'h000, 0, 0, 1);
    chk("double_borrow", co0, 12'h099);

    drive(1, 12'h002, 0, 0, 0); drive(0, 12'h000, 1, 0, 0); drive(0, 12'h000, 0, 0, 1);
    chk("cnt_001", co0, 12'h001);
    chk("no_done_001", {11'b0, dn0}, 12'h000);
    drive(0, 12'h000, 0, 0, 1);
    chk("cnt_000", co0, 12'h000);
    chk("done_pulse", {11'b0, dn0}, 12'h001);
    chk("done_state", {11'b0, run0}, 12'h000);
    chk("wrap_done_pulse", {11'b0, dn1}, 12'h001);
    chk("wrap_still_run", {11'b0, run1}, 12'h001);
    drive(0, 12'h000, 0, 0, 0);
    chk("done_one_cycle", {11'b0, dn0}, 12'h000);
    drive(0, 12'h000, 0, 0, 1);
    chk("done_hold", co0, 12'h000);
    chk("done_no_repulse", {11'b0, dn0}, 12'h000);

    drive(1, 12'h1A5, 0, 0, 0);
    chk("clamp_1A5", co0, 12'h195);
    chk("invalid_set", {11'b0, inv0}, 12'h001);
    drive(1, 12'h150, 0, 0, 0);
    chk("invalid_sticky", {11'b0, inv0}, 12'h001);

    drive(0, 12'h000, 1, 0, 0); drive(0, 12'h000, 0, 1, 0);
    chk("paused_not_running", {11'b0, run0}, 12'h000);
    drive(0, 12'h000, 0, 0, 1);
    chk("paused_hold", co0, 12'h150);
    drive(0, 12'h000, 1, 0, 0); drive(0, 12'h000, 0, 0, 1);
    chk("resume_149", co0, 12'h149);

    drive(1, 12'h300, 1, 0, 1);
    chk("load_wins_cnt", co0, 12'h300);
    chk("load_wins_idle", {11'b0, run0}, 12'h000);

    drive(1, 12'h001, 0, 0, 0); drive(0, 12'h000, 1, 0, 0); drive(0, 12'h000, 0, 0, 1);
    chk("wrap_to_0", co1, 12'h000);
    chk("wrap_done1", {11'b0, dn1}, 12'h001);
    drive(0, 12'h000, 0, 0, 1);
    chk("wrap_reload", co1, 12'h001);
    chk("wrap_reload_nodone", {11'b0, dn1}, 12'h000);
    drive(0, 12'h000, 0, 0, 1);
    chk("wrap_to_0_again", co1, 12'h000);
    chk("wrap_done2", {11'b0, dn1}, 12'h001);

    drive(1, 12'h437, 0, 0, 0); drive(0, 12'h000, 1, 0, 0);
    #1; rst = 1'b1; tick = 1'b1;
    #1;
    chk("async_count", co0, 12'h000);
    chk("async_zero", {11'b0, zr0}, 12'h001);
    chk("async_running", {11'b0, run0}, 12'h000);
    chk("async_invalid", {11'b0, inv0}, 12'h000);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0; tick = 1'b0;
    drive(0, 12'h000, 0, 0, 1);
    chk("post_rst_idle", co0, 12'h000);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        #1; rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
      end else begin
        case ($urandom_range(0, 3))
          0:       lv = 12'($urandom_range(0, 9));
          1:       lv = {4'h0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
          2:       lv = 12'($urandom);
          default: lv = 12'h000;
        endcase
        drive($urandom_range(0, 15) == 0, lv, $urandom_range(0, 7) == 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
      end
    end

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
